// File: rtl/boot_mem_arbiter.sv
// boot_mem_arbiter: owns the program-memory port, sequencing serial boot
// loading against CPU instruction fetch, with word count and checksum.
//
// Ports:
//   sclk, rst            clock, synchronous active-high reset
//   prog                 boot-mode request level
//   boot_we/addr/data    loader write pulse, address, data
//   cpu_req/addr         CPU fetch request and address
//   cpu_gnt              fetch accepted this cycle (combinational)
//   cpu_rst              CPU reset hold (registered)
//   mem_en/we/addr/wdata registered memory port
//   word_cnt, csum       boot session write count and 16-bit sum
//   boot_done            RUN was entered after a boot session
//   drop_err             sticky: a loader write arrived outside BOOT
module boot_mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int DRAIN_N = 4
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          prog,
  input  logic          boot_we,
  input  logic [AW-1:0] boot_addr,
  input  logic [DW-1:0] boot_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rst,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW:0]   word_cnt,
  output logic [15:0]   csum,
  output logic          boot_done,
  output logic          drop_err
);

  localparam int CW = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
  localparam logic [CW-1:0] CTR_LOAD = CW'(DRAIN_N - 1);
  localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    BOOT       = 2'd1,
    DRAIN      = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] ctr, ctr_d;
  logic          cpu_rst_d;
  logic          mem_en_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [AW:0]   word_cnt_d;
  logic [15:0]   csum_d;
  logic          boot_done_d, drop_err_d;
  logic          sess, sess_d;
  logic [15:0]   data16;

  logic enter_boot, enter_drain, enter_run;

  // Checksum operand: boot_data zero-extended or truncated to 16 bits.
  generate
    if (DW >= 16) begin : g_trunc
      assign data16 = boot_data[15:0];
    end else begin : g_zext
      assign data16 = {{(16-DW){1'b0}}, boot_data};
    end
  endgenerate

  // Transition decisions come from the registered state only.
  assign enter_boot  = (state != BOOT) && prog;
  assign enter_drain = !prog &&
                       ((state == RESET_HOLD) || (state == BOOT));
  assign enter_run   = (state == DRAIN) && !prog && (ctr == '0);

  always_comb begin
    state_d     = state;
    ctr_d       = ctr;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    word_cnt_d  = word_cnt;
    csum_d      = csum;
    boot_done_d = boot_done;
    sess_d      = sess;
    cpu_gnt     = 1'b0;
    drop_err_d  = drop_err | (boot_we && (state != BOOT));

    unique case (state)
      RESET_HOLD: begin
        state_d = prog ? BOOT : DRAIN;
      end
      BOOT: begin
        if (boot_we) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = boot_addr;
          mem_wdata_d = boot_data;
          csum_d      = csum + data16;
          if (word_cnt != CNT_MAX)
            word_cnt_d = word_cnt + (AW+1)'(1);
        end
        if (!prog)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (prog)
          state_d = BOOT;
        else if (ctr == '0)
          state_d = RUN;
        else
          ctr_d = ctr - CW'(1);
      end
      RUN: begin
        cpu_gnt = cpu_req;
        if (cpu_req) begin
          mem_en_d   = 1'b1;
          mem_addr_d = cpu_addr;
        end
        if (prog)
          state_d = BOOT;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase

    // A new session forgets the previous one's totals.
    if (enter_boot) begin
      word_cnt_d  = '0;
      csum_d      = '0;
      boot_done_d = 1'b0;
      sess_d      = 1'b1;
    end
    if (enter_drain)
      ctr_d = CTR_LOAD;
    if (enter_run)
      boot_done_d = sess;

    // Low exactly while the registered state is RUN.
    cpu_rst_d = !(enter_run || ((state == RUN) && !prog));
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= RESET_HOLD;
      ctr       <= '0;
      cpu_rst   <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      boot_done <= 1'b0;
      drop_err  <= 1'b0;
      sess      <= 1'b0;
    end else begin
      state     <= state_d;
      ctr       <= ctr_d;
      cpu_rst   <= cpu_rst_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      word_cnt  <= word_cnt_d;
      csum      <= csum_d;
      boot_done <= boot_done_d;
      drop_err  <= drop_err_d;
      sess      <= sess_d;
    end
  end

  a_we_not_run : assert property (
    @(posedge sclk) disable iff (rst) mem_we |-> (state != RUN));
  a_gnt_run : assert property (
    @(posedge sclk) disable iff (rst) cpu_gnt |-> (state == RUN));
  a_rst_run : assert property (
    @(posedge sclk) disable iff (rst) !cpu_rst |-> (state == RUN));

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// tb_boot_mem_arbiter: directed vector table, saturation sequence and
// randomized run against a behavioural model.
module tb_boot_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DN = 4;

  logic        sclk = 1'b0;
  logic        rst, prog, boot_we, cpu_req;
  logic [7:0]  boot_addr, cpu_addr;
  logic [15:0] boot_data;
  logic        cpu_gnt, cpu_rst, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_cnt;
  logic [15:0] csum;
  logic        boot_done, drop_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sclk = ~sclk;

  boot_mem_arbiter #(.AW(AW), .DW(DW), .DRAIN_N(DN)) dut (
    .sclk(sclk), .rst(rst), .prog(prog),
    .boot_we(boot_we), .boot_addr(boot_addr), .boot_data(boot_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rst(cpu_rst), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .csum(csum),
    .boot_done(boot_done), .drop_err(drop_err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, prog, we;
    logic [7:0]  a;
    logic [15:0] d;
    logic        req;
    logic [7:0]  ca;
    logic        gnt, crst, en, mwe;
    logic [7:0]  maddr;
    logic [8:0]  wc;
    logic [15:0] cs;
    logic        bd, de;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: modes and remaining drain cycles.
  localparam int M_HOLD  = 0;
  localparam int M_BOOT  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_RUN   = 3;

  int m_mode, m_left, m_wc, m_cs, m_addr, m_wdata;
  bit m_crst, m_en, m_we, m_bd, m_de, m_had;

  task automatic model_edge();
    int nxt;
    if (rst) begin
      m_mode = M_HOLD; m_left = 0; m_crst = 1;
      m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wc = 0; m_cs = 0; m_bd = 0; m_de = 0; m_had = 0;
      return;
    end
    nxt = m_mode;
    m_en = 0;
    m_we = 0;
    if (boot_we && m_mode != M_BOOT) m_de = 1;
    case (m_mode)
      M_HOLD: nxt = prog ? M_BOOT : M_DRAIN;
      M_BOOT: begin
        if (boot_we) begin
          m_en = 1; m_we = 1;
          m_addr = boot_addr; m_wdata = boot_data;
          if (m_wc < (1 << AW)) m_wc = m_wc + 1;
          m_cs = (m_cs + int'(boot_data)) % 65536;
        end
        if (!prog) nxt = M_DRAIN;
      end
      M_DRAIN: begin
        if (prog) nxt = M_BOOT;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) nxt = M_RUN;
        end
      end
      default: begin
        if (cpu_req) begin
          m_en = 1;
          m_addr = cpu_addr;
        end
        if (prog) nxt = M_BOOT;
      end
    endcase
    if (nxt == M_BOOT && m_mode != M_BOOT) begin
      m_wc = 0; m_cs = 0; m_bd = 0; m_had = 1;
    end
    if (nxt == M_DRAIN && m_mode != M_DRAIN) m_left = DN;
    if (nxt == M_RUN && m_mode != M_RUN) m_bd = m_had;
    m_crst = (nxt != M_RUN);
    m_mode = nxt;
  endtask

  task automatic drive(input logic r, p, we, input logic [7:0] a,
                       input logic [15:0] d, input logic rq,
                       input logic [7:0] ca);
    rst = r; prog = p; boot_we = we; boot_addr = a;
    boot_data = d; cpu_req = rq; cpu_addr = ca;
  endtask

  initial begin
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    @(posedge sclk);

    //          rst prog we  a      d          req ca     gnt crst en we maddr  wc     cs         bd de
    tbl.push_back('{1, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd0, 16'h0000, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd0, 16'h0000, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h10, 16'h1234, 1, 8'h55, 0, 1, 1, 1, 8'h10, 9'd1, 16'h1234, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h11, 16'hFFFF, 0, 8'h00, 0, 1, 1, 1, 8'h11, 9'd2, 16'h1233, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h12, 16'h0002, 1, 8'h00, 0, 1, 1, 1, 8'h12, 9'd3, 16'h1235, 0, 0});
    tbl.push_back('{0, 0, 1, 8'h13, 16'h0001, 0, 8'h00, 0, 1, 1, 1, 8'h13, 9'd4, 16'h1236, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd4, 16'h1236, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd4, 16'h1236, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd4, 16'h1236, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 8'h00, 9'd4, 16'h1236, 1, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 1, 8'h12, 1, 0, 1, 0, 8'h12, 9'd4, 16'h1236, 1, 0});
    tbl.push_back('{0, 0, 1, 8'h20, 16'h5555, 0, 8'h00, 0, 0, 0, 0, 8'h00, 9'd4, 16'h1236, 1, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 1, 8'h34, 1, 0, 1, 0, 8'h34, 9'd4, 16'h1236, 1, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 16'h0000, 1, 8'h40, 1, 1, 1, 0, 8'h40, 9'd0, 16'h0000, 0, 1});
    tbl.push_back('{0, 1, 1, 8'h01, 16'h00AA, 0, 8'h00, 0, 1, 1, 1, 8'h01, 9'd1, 16'h00AA, 0, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd1, 16'h00AA, 0, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd1, 16'h00AA, 0, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd0, 16'h0000, 0, 1});
    tbl.push_back('{0, 1, 1, 8'h02, 16'h0003, 0, 8'h00, 0, 1, 1, 1, 8'h02, 9'd1, 16'h0003, 0, 1});
    tbl.push_back('{1, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd0, 16'h0000, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 9'd0, 16'h0000, 0, 0});

    foreach (tbl[i]) begin
      @(negedge sclk);
      drive(tbl[i].rst, tbl[i].prog, tbl[i].we, tbl[i].a,
            tbl[i].d, tbl[i].req, tbl[i].ca);
      #1;
      chk($sformatf("v%0d_gnt", i), cpu_gnt, tbl[i].gnt);
      @(posedge sclk);
      #1;
      chk($sformatf("v%0d_cpu_rst", i), cpu_rst, tbl[i].crst);
      chk($sformatf("v%0d_mem_en", i), mem_en, tbl[i].en);
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].mwe);
      if (tbl[i].en || tbl[i].rst)
        chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d_word_cnt", i), word_cnt, tbl[i].wc);
      chk($sformatf("v%0d_csum", i), csum, tbl[i].cs);
      chk($sformatf("v%0d_boot_done", i), boot_done, tbl[i].bd);
      chk($sformatf("v%0d_drop_err", i), drop_err, tbl[i].de);
    end

    // Saturation: 257 writes in one session.
    @(negedge sclk);
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    @(negedge sclk);
    drive(0, 1, 0, 8'h00, 16'h0000, 0, 8'h00);
    for (int i = 0; i < 257; i++) begin
      @(negedge sclk);
      drive(0, 1, 1, 8'(i), 16'h0001, 0, 8'h00);
      @(posedge sclk);
      #1;
      if (i == 254) chk("sat_255", word_cnt, 9'd255);
      if (i == 255) chk("sat_256", word_cnt, 9'd256);
      if (i == 256) begin
        chk("sat_257_cnt", word_cnt, 9'd256);
        chk("sat_257_we", mem_we, 1'b1);
        chk("sat_257_addr", mem_addr, 8'h00);
      end
    end

    // Randomized run against the model.
    prog = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) prog = ~prog;
      boot_we   = 1'($urandom_range(0, 1));
      boot_addr = 8'($urandom);
      boot_data = 16'($urandom);
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom);
      #1;
      if (i != 0)
        chk("r_gnt", cpu_gnt, (m_mode == M_RUN) && cpu_req);
      model_edge();
      @(posedge sclk);
      #1;
      chk("r_cpu_rst", cpu_rst, m_crst);
      chk("r_mem_en", mem_en, m_en);
      chk("r_mem_we", mem_we, m_we);
      chk("r_mem_addr", mem_addr, 64'(m_addr));
      chk("r_mem_wdata", mem_wdata, 64'(m_wdata));
      chk("r_word_cnt", word_cnt, 64'(m_wc));
      chk("r_csum", csum, 64'(m_cs));
      chk("r_boot_done", boot_done, m_bd);
      chk("r_drop_err", drop_err, m_de);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
